// File: rtl/brq_ifu_fetch_fifo_if.sv
// Handshake bundle between the fetch FIFO, the instruction memory response path and IF/ID.
// The slave modport is the FIFO itself; the master modport is its environment.
interface brq_ifu_fetch_fifo_if #(
    parameter int Depth = 3
);
    logic                         clear_i;
    logic [31:0]                  in_addr_i;
    logic                         in_valid_i;
    logic [31:0]                  in_rdata_i;
    logic                         in_err_i;
    logic                         in_ready_o;
    logic [$clog2(Depth+1)-1:0]   free_cnt_o;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [31:0]                  out_rdata_o;
    logic [31:0]                  out_addr_o;
    logic                         out_err_o;
    logic                         out_err_plus2_o;

    modport master (
        output clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        input  in_ready_o, free_cnt_o, out_valid_o, out_rdata_o, out_addr_o,
               out_err_o, out_err_plus2_o
    );

    modport slave (
        input  clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        output in_ready_o, free_cnt_o, out_valid_o, out_rdata_o, out_addr_o,
               out_err_o, out_err_plus2_o
    );
endinterface

// File: rtl/brq_ifu_fetch_fifo.sv
// Fetch FIFO and RISC-V 16/32-bit instruction aligner for the brq IFU.
// Optional macro BRQ_FETCH_FIFO_BYPASS_EN forwards an arriving word straight into the aligner.
module brq_ifu_fetch_fifo #(
    parameter int Depth = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    brq_ifu_fetch_fifo_if.slave fifo_if
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [31:0]     data_q [Depth];
    logic            err_q  [Depth];
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, rptr_nxt;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;

    logic        push, push_store, pop, free_w0, free_stored;
    logic        w0_vld, w1_vld, w0_err_raw, w1_err_raw, w0_err, w1_err;
    logic [31:0] w0_data;
    logic [15:0] w1_lo;
    logic        half, compressed, straddle, out_valid;
    logic        unused_addr0;

    function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign unused_addr0 = fifo_if.in_addr_i[0];
    assign rptr_nxt     = incPtr(rptr_q);

    assign fifo_if.in_ready_o = (cnt_q < DepthCnt);
    assign fifo_if.free_cnt_o = DepthCnt - cnt_q;
    assign push = fifo_if.in_valid_i & fifo_if.in_ready_o & ~fifo_if.clear_i;

    // W0/W1 are the two oldest words visible to the aligner.
    always_comb begin
        w0_vld     = (cnt_q != '0);
        w0_data    = data_q[rptr_q];
        w0_err_raw = err_q[rptr_q];
        w1_vld     = (cnt_q > CntW'(1));
        w1_lo      = data_q[rptr_nxt][15:0];
        w1_err_raw = err_q[rptr_nxt];
`ifdef BRQ_FETCH_FIFO_BYPASS_EN
        if (push) begin
            if (cnt_q == '0) begin
                w0_vld     = 1'b1;
                w0_data    = fifo_if.in_rdata_i;
                w0_err_raw = fifo_if.in_err_i;
            end else if (cnt_q == CntW'(1)) begin
                w1_vld     = 1'b1;
                w1_lo      = fifo_if.in_rdata_i[15:0];
                w1_err_raw = fifo_if.in_err_i;
            end
        end
`endif
    end

    assign w0_err     = w0_vld & w0_err_raw;
    assign w1_err     = w1_vld & w1_err_raw;
    assign half       = addr_q[1];
    assign compressed = half ? (w0_data[17:16] != 2'b11) : (w0_data[1:0] != 2'b11);
    assign straddle   = half & ~compressed;

    // A straddling instruction with a faulting first word is presented without waiting for W1.
    assign out_valid = w0_vld & (~straddle | w1_vld | w0_err);

    assign fifo_if.out_valid_o     = out_valid;
    assign fifo_if.out_rdata_o     = half ? {(w1_vld ? w1_lo : 16'h0), w0_data[31:16]} : w0_data;
    assign fifo_if.out_addr_o      = addr_q;
    assign fifo_if.out_err_o       = w0_err | (straddle & w1_err);
    assign fifo_if.out_err_plus2_o = straddle & w1_err & ~w0_err;

    assign pop         = out_valid & fifo_if.out_ready_i;
    assign free_w0     = pop & (half | ~compressed);
    assign free_stored = free_w0 & (cnt_q != '0);
    // With an empty FIFO the only way W0 can be freed is via the bypass, so that word is never stored.
    assign push_store  = push & ~(free_w0 & (cnt_q == '0));

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (fifo_if.clear_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
            addr_d = {fifo_if.in_addr_i[31:1], 1'b0};
        end else begin
            if (push_store) wptr_d = incPtr(wptr_q);
            if (free_stored) rptr_d = rptr_nxt;
            if (pop) addr_d = addr_q + (compressed ? 32'd2 : 32'd4);
            cnt_d = cnt_q + CntW'(push_store) - CntW'(free_stored);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
        end else if (push_store) begin
            data_q[wptr_q] <= fifo_if.in_rdata_i;
            err_q[wptr_q]  <= fifo_if.in_err_i;
        end
    end
endmodule

// File: tb/tb_brq_ifu_fetch_fifo.sv
// Self-checking bench for brq_ifu_fetch_fifo: directed steps plus random traffic
// compared against a halfword-stream reference model.
module tb_brq_ifu_fetch_fifo;
    localparam int Depth = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model: queue of stored words {err, data} and the current PC.
    logic [32:0] mq[$];
    logic [31:0] maddr;

    logic        expValid, expErr, expPlus2;
    logic [31:0] expRdata;
    int          expNeed;

    brq_ifu_fetch_fifo_if #(.Depth(Depth)) fifo ();
    brq_ifu_fetch_fifo #(.Depth(Depth)) dut (.clk_i(clk), .rst_i(rst), .fifo_if(fifo));

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expected);
        end
    endtask

    function automatic logic [15:0] hwAt(input int idx);
        logic [32:0] w;
        w = mq[idx / 2];
        return (idx % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    // The stored words form a halfword stream; the instruction starts at halfword maddr[1].
    task automatic computeExp();
        int s, avail;
        logic [15:0] first, second;
        logic firstErr, secondErr;
        s = int'(maddr[1]);
        avail = 2 * mq.size() - s;
        expValid = 1'b0; expRdata = '0; expErr = 1'b0; expPlus2 = 1'b0; expNeed = 1;
        if (avail > 0) begin
            first     = hwAt(s);
            expNeed   = (first[1:0] != 2'b11) ? 1 : 2;
            firstErr  = mq[s / 2][32];
            expValid  = (avail >= expNeed) || firstErr;
            second    = (avail >= 2) ? hwAt(s + 1) : 16'h0;
            expRdata  = {second, first};
            secondErr = (expNeed == 2 && avail >= 2) ? mq[(s + 1) / 2][32] : 1'b0;
            expErr    = firstErr | secondErr;
            expPlus2  = (expNeed == 2) && ((s + 1) / 2 != s / 2) && secondErr && !firstErr;
        end
    endtask

    task automatic modelStep(input logic clr, input logic [31:0] addr, input logic vld,
                             input logic [31:0] data, input logic err, input logic rdy);
        int s;
        logic pushOk;
        computeExp();
        if (clr) begin
            mq.delete();
            maddr = {addr[31:1], 1'b0};
        end else begin
            pushOk = vld && (mq.size() < Depth);
            if (expValid && rdy) begin
                s = int'(maddr[1]) + expNeed;
                maddr = maddr + 32'(2 * expNeed);
                while (s >= 2) begin
                    void'(mq.pop_front());
                    s -= 2;
                end
            end
            if (pushOk) mq.push_back({err, data});
        end
    endtask

    task automatic checkOutput(input string tag);
        computeExp();
        checkVal({tag, "_valid"}, 32'(fifo.out_valid_o), 32'(expValid));
        checkVal({tag, "_ready"}, 32'(fifo.in_ready_o), 32'(mq.size() < Depth));
        checkVal({tag, "_free"}, 32'(fifo.free_cnt_o), 32'(Depth - mq.size()));
        checkVal({tag, "_addr"}, fifo.out_addr_o, maddr);
        if (expValid) begin
            checkVal({tag, "_rdata"}, fifo.out_rdata_o, expRdata);
            checkVal({tag, "_err"}, 32'(fifo.out_err_o), 32'(expErr));
            checkVal({tag, "_plus2"}, 32'(fifo.out_err_plus2_o), 32'(expPlus2));
        end
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_valid"}, 32'(fifo.out_valid_o), 32'd0);
        checkVal({tag, "_rdata"}, fifo.out_rdata_o, 32'd0);
        checkVal({tag, "_addr"}, fifo.out_addr_o, 32'd0);
        checkVal({tag, "_err"}, 32'(fifo.out_err_o), 32'd0);
        checkVal({tag, "_plus2"}, 32'(fifo.out_err_plus2_o), 32'd0);
        checkVal({tag, "_ready"}, 32'(fifo.in_ready_o), 32'd1);
        checkVal({tag, "_free"}, 32'(fifo.free_cnt_o), 32'(Depth));
    endtask

    // Drive one cycle of inputs, check registered outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input string tag, input logic clr, input logic [31:0] addr,
                                 input logic vld, input logic [31:0] data, input logic err,
                                 input logic rdy);
        fifo.clear_i     = clr;
        fifo.in_addr_i   = addr;
        fifo.in_valid_i  = vld;
        fifo.in_rdata_i  = data;
        fifo.in_err_i    = err;
        fifo.out_ready_i = rdy;
        @(negedge clk);
        checkOutput(tag);
        modelStep(clr, addr, vld, data, err, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        fifo.clear_i = 1'b0; fifo.in_addr_i = '0; fifo.in_valid_i = 1'b0;
        fifo.in_rdata_i = '0; fifo.in_err_i = 1'b0; fifo.out_ready_i = 1'b0;
        mq.delete();
        maddr = '0;
        #2;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single 32-bit word at 0x80.
        applyStimulus("t1_clr", 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t1_push", 1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        checkVal("t1_valid", 32'(fifo.out_valid_o), 32'd1);
        checkVal("t1_rdata", fifo.out_rdata_o, 32'h0000_0013);
        checkVal("t1_addr", fifo.out_addr_o, 32'h80);
        applyStimulus("t1_pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkVal("t1_addr_next", fifo.out_addr_o, 32'h84);
        checkVal("t1_free", 32'(fifo.free_cnt_o), 32'(Depth));

        // Two compressed instructions in one word.
        applyStimulus("t2_clr", 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t2_push", 1'b0, '0, 1'b1, 32'h4501_4501, 1'b0, 1'b0);
        checkVal("t2_rdata0", 32'(fifo.out_rdata_o[15:0]), 32'h4501);
        applyStimulus("t2_pop0", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkVal("t2_addr1", fifo.out_addr_o, 32'h82);
        checkVal("t2_free1", 32'(fifo.free_cnt_o), 32'(Depth - 1));
        checkVal("t2_rdata1", 32'(fifo.out_rdata_o[15:0]), 32'h4501);
        applyStimulus("t2_pop1", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkVal("t2_free2", 32'(fifo.free_cnt_o), 32'(Depth));

        // Odd-halfword start; upper half 0x0013 is a 32-bit opcode that straddles into W1.
        applyStimulus("t3_clr", 1'b1, 32'h103, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t3_push0", 1'b0, '0, 1'b1, 32'h0013_4501, 1'b0, 1'b0);
        checkVal("t3_wait_w1", 32'(fifo.out_valid_o), 32'd0);
        checkVal("t3_addr", fifo.out_addr_o, 32'h102);
        applyStimulus("t3_push1", 1'b0, '0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        checkVal("t3_valid", 32'(fifo.out_valid_o), 32'd1);
        checkVal("t3_rdata", fifo.out_rdata_o, 32'h0000_0013);
        applyStimulus("t3_pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Fill to full, drop a word, then free one entry.
        applyStimulus("t4_clr", 1'b1, 32'h200, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus("t4_fill", 1'b0, '0, 1'b1, 32'h1000_0013 + 32'(i << 8), 1'b0, 1'b0);
        checkVal("t4_ready_full", 32'(fifo.in_ready_o), 32'd0);
        checkVal("t4_free_full", 32'(fifo.free_cnt_o), 32'd0);
        applyStimulus("t4_pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkVal("t4_ready_again", 32'(fifo.in_ready_o), 32'd1);
        for (int i = 0; i < 10; i++)
            applyStimulus("t4_wrap", 1'b0, '0, 1'b1, 32'h2000_0013 + 32'(i << 8), 1'b0, 1'b1);

        // Straddling instruction with only the second word faulting.
        applyStimulus("t5_clr", 1'b1, 32'h302, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t5_w0", 1'b0, '0, 1'b1, 32'h0003_0000, 1'b0, 1'b0);
        applyStimulus("t5_w1", 1'b0, '0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        checkVal("t5_err", 32'(fifo.out_err_o), 32'd1);
        checkVal("t5_plus2", 32'(fifo.out_err_plus2_o), 32'd1);
        // First word faulting with W1 absent is still presented.
        applyStimulus("t5_clr2", 1'b1, 32'h302, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t5_w0err", 1'b0, '0, 1'b1, 32'h0003_0000, 1'b1, 1'b0);
        checkVal("t5b_valid", 32'(fifo.out_valid_o), 32'd1);
        checkVal("t5b_err", 32'(fifo.out_err_o), 32'd1);
        checkVal("t5b_plus2", 32'(fifo.out_err_plus2_o), 32'd0);
        applyStimulus("t5_pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Clear wins over a simultaneous push and pop.
        applyStimulus("t6_clr", 1'b1, 32'h400, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t6_p0", 1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        applyStimulus("t6_p1", 1'b0, '0, 1'b1, 32'h0000_0093, 1'b0, 1'b0);
        applyStimulus("t6_all", 1'b1, 32'h503, 1'b1, 32'h0000_0113, 1'b0, 1'b1);
        checkVal("t6_free", 32'(fifo.free_cnt_o), 32'(Depth));
        checkVal("t6_valid", 32'(fifo.out_valid_o), 32'd0);
        checkVal("t6_addr", fifo.out_addr_o, 32'h502);

        // PC wraps at 2^32.
        applyStimulus("t7_clr", 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus("t7_push", 1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        applyStimulus("t7_pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkVal("t7_addr_wrap", fifo.out_addr_o, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(1, 0) == 1) d[1:0] = 2'b11;
            if ($urandom_range(1, 0) == 1) d[17:16] = 2'b11;
            applyStimulus("rnd", ($urandom_range(29, 0) == 0), $urandom,
                          ($urandom_range(9, 0) < 6), d, ($urandom_range(7, 0) == 0),
                          ($urandom_range(9, 0) < 6));
        end

        // Asynchronous reset in the middle of traffic.
        applyStimulus("t8_p0", 1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        applyStimulus("t8_p1", 1'b0, '0, 1'b1, 32'h0000_0093, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkReset("t8_reset");
        mq.delete();
        maddr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("t8_after", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
